// File: rtl/buffered_router_if.sv
// Bundle of the producer-side and consumer-side signals of buffered_router.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. Ready never depends on valid. The
// producer holds its payload stable while valid is high and ready is low.
// On the output side each channel i has its own valid/ready pair
// (dout_valid[i] / dout_ready[i]); ready without valid has no effect.
interface buffered_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 4
);
  localparam int AW = $clog2(NUM_OUT);

  logic [DATA_WIDTH-1:0]         din;
  logic                          din_valid;
  logic [AW-1:0]                 addr;
  logic                          bcast;
  logic                          din_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0] dout;
  logic [NUM_OUT-1:0]            dout_valid;
  logic [NUM_OUT-1:0]            dout_ready;
  logic [NUM_OUT-1:0]            full;

  // Producer and consumers together drive the router.
  modport master (
    output din, din_valid, addr, bcast, dout_ready,
    input  din_ready, dout, dout_valid, full
  );

  // The router itself.
  modport slave (
    input  din, din_valid, addr, bcast, dout_ready,
    output din_ready, dout, dout_valid, full
  );
endinterface

// File: rtl/buffered_router.sv
// Steers one input stream to NUM_OUT per-channel FIFOs by address, with an
// all-or-nothing broadcast mode. Each channel FIFO is first-word-fall-through
// and drains independently, so a stalled consumer only blocks its own lane.
module buffered_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  buffered_router_if.slave  bus
);
  localparam int AW = $clog2(NUM_OUT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr_q [NUM_OUT];
  logic [PW-1:0]         wr_ptr_d [NUM_OUT];
  logic [PW-1:0]         rd_ptr_q [NUM_OUT];
  logic [PW-1:0]         rd_ptr_d [NUM_OUT];
  logic [CW-1:0]         count_q  [NUM_OUT];
  logic [CW-1:0]         count_d  [NUM_OUT];
  logic [DATA_WIDTH-1:0] mem_q    [NUM_OUT][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [NUM_OUT][FIFO_DEPTH];

  logic [NUM_OUT-1:0] full_w;
  logic [NUM_OUT-1:0] valid_w;
  logic [NUM_OUT-1:0] push_w;
  logic [NUM_OUT-1:0] pop_w;
  logic               accept_w;

  // Channel status derived purely from registered counts.
  always_comb begin
    full_w  = '0;
    valid_w = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      full_w[i]  = (count_q[i] == CW'(FIFO_DEPTH));
      valid_w[i] = (count_q[i] != '0);
    end
  end

  // Input acceptance: a full target refuses even if it is popped this cycle,
  // and a broadcast waits until every channel has room.
  always_comb begin
    bus.din_ready = bus.bcast ? ~|full_w : !full_w[bus.addr];
    accept_w      = bus.din_valid && bus.din_ready;
    push_w        = '0;
    pop_w         = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      push_w[i] = accept_w && (bus.bcast || (bus.addr == AW'(i)));
      pop_w[i]  = valid_w[i] && bus.dout_ready[i];
    end
  end

  // Next pointer/count/storage values for every channel.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i] + CW'(push_w[i]) - CW'(pop_w[i]);
      if (push_w[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.din;
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop_w[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
    end
  end

  // Head words, zeroed on empty lanes.
  always_comb begin
    bus.dout       = '0;
    bus.dout_valid = valid_w;
    bus.full       = full_w;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (valid_w[i]) begin
        bus.dout[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  // Pointer and count registers; reset wins over any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; counts alone decide what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
